// File: rtl/chime_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : chime_alarm_ctrl
//  Purpose  : Hourly pip chime plus a daily alarm with snooze and stop.
//             Reads BCD time from the time counters and drives a gated
//             tone onto the buzzer line. Registered, single-clock design.
//  Ports    : CLK          in  system clock, rising edge
//             nCR          in  asynchronous active-low reset
//             Hour/Minute/Second  in [7:0]  current time, BCD
//             AlarmEn      in  alarm enable (level)
//             AlarmHour/AlarmMinute in [7:0] alarm time, BCD
//             Snooze/Stop  in  debounced keys, act on rising edge
//             ALARM        out buzzer drive (gated tone)
//             Chiming      out high while an hourly pip sounds
//             Ringing      out high while the alarm rings
//  Revision : 1.0  initial release
// ============================================================================
module chime_alarm_ctrl #(
  parameter int CLK_HZ     = 2000,
  parameter int LO_DIV     = 4,
  parameter int HI_DIV     = 2,
  parameter int PIP_COUNT  = 5,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int SNOOZE_MAX = 3
) (
  input  logic       CLK,
  input  logic       nCR,
  input  logic [7:0] Hour,
  input  logic [7:0] Minute,
  input  logic [7:0] Second,
  input  logic       AlarmEn,
  input  logic [7:0] AlarmHour,
  input  logic [7:0] AlarmMinute,
  input  logic       Snooze,
  input  logic       Stop,
  output logic       ALARM,
  output logic       Chiming,
  output logic       Ringing
);

  // A divider longer than the clock itself makes no sense; clamp to a
  // valid half-period so a bad parameter cannot produce a zero-width counter.
  localparam int LO_HALF = (LO_DIV >= 2 && LO_DIV <= CLK_HZ) ? LO_DIV / 2 : 1;
  localparam int HI_HALF = (HI_DIV >= 2 && HI_DIV <= CLK_HZ) ? HI_DIV / 2 : 1;
  localparam int LO_W    = (LO_HALF > 1) ? $clog2(LO_HALF) : 1;
  localparam int HI_W    = (HI_HALF > 1) ? $clog2(HI_HALF) : 1;
  localparam int SNZ_W   = ($clog2(SNOOZE_MAX + 1) < 2) ? 2 : $clog2(SNOOZE_MAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RING   = 2'd1;
  localparam logic [1:0] S_SNOOZE = 2'd2;

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  logic [1:0]       state, state_nx;
  logic [LO_W-1:0]  lo_cnt;
  logic [HI_W-1:0]  hi_cnt;
  logic             lo_tone, hi_tone;
  logic [7:0]       sec_q, min_q;
  logic             snooze_q, stop_q;
  logic [7:0]       ring_cnt;
  logic [5:0]       min_cnt;
  logic [SNZ_W-1:0] snz_cnt;

  logic sec_tick, min_tick, snz_edge, stop_edge;
  logic alarm_match;
  logic ring_clr, ring_inc, snz_clr, snz_inc, min_clr, min_inc;
  logic lo_sec, chime_ok, chime_lo, chime_hi, ring_tone;

  assign sec_tick  = (Second != sec_q);
  assign min_tick  = (Minute != min_q);
  assign snz_edge  = Snooze & ~snooze_q;
  assign stop_edge = Stop & ~stop_q;

  assign alarm_match = sec_tick && (Second == 8'h00) &&
                       (Hour == AlarmHour) && (Minute == AlarmMinute);

  // Free-running tone dividers; gating never touches their phase.
  always_ff @(posedge CLK or negedge nCR) begin
    if (!nCR) begin
      lo_cnt  <= '0;
      lo_tone <= 1'b0;
      hi_cnt  <= '0;
      hi_tone <= 1'b0;
    end else begin
      if (lo_cnt == LO_W'(LO_HALF - 1)) begin
        lo_cnt  <= '0;
        lo_tone <= ~lo_tone;
      end else begin
        lo_cnt <= lo_cnt + LO_W'(1);
      end
      if (hi_cnt == HI_W'(HI_HALF - 1)) begin
        hi_cnt  <= '0;
        hi_tone <= ~hi_tone;
      end else begin
        hi_cnt <= hi_cnt + HI_W'(1);
      end
    end
  end

  // Next-state logic. Disabling the alarm overrides everything; within
  // RING and SNOOZE a Stop edge is checked before Snooze.
  always_comb begin
    state_nx = state;
    ring_clr = 1'b0;
    ring_inc = 1'b0;
    snz_clr  = 1'b0;
    snz_inc  = 1'b0;
    min_clr  = 1'b0;
    min_inc  = 1'b0;
    if (!AlarmEn) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (alarm_match) begin
            state_nx = S_RING;
            ring_clr = 1'b1;
            snz_clr  = 1'b1;
          end
        end
        S_RING: begin
          if (stop_edge) begin
            state_nx = S_IDLE;
          end else if (snz_edge && (snz_cnt < SNZ_W'(SNOOZE_MAX))) begin
            state_nx = S_SNOOZE;
            snz_inc  = 1'b1;
            min_clr  = 1'b1;
          end else if (sec_tick) begin
            ring_inc = 1'b1;
            if (ring_cnt == 8'(RING_SECS - 1))
              state_nx = S_IDLE;
          end
        end
        S_SNOOZE: begin
          if (stop_edge) begin
            state_nx = S_IDLE;
          end else if (min_tick) begin
            if (min_cnt == 6'(SNOOZE_MIN - 1)) begin
              state_nx = S_RING;
              ring_clr = 1'b1;
            end else begin
              min_inc = 1'b1;
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Low pips fall on the odd seconds just before :59 (57, 55, ...).
  always_comb begin
    lo_sec = 1'b0;
    for (int k = 1; k < PIP_COUNT; k++) begin
      if (Second == bcd8(59 - 2 * k))
        lo_sec = 1'b1;
    end
  end

  // Chime only from IDLE/SNOOZE and never on a cycle that enters RING.
  assign chime_ok  = ((state == S_IDLE) || (state == S_SNOOZE)) &&
                     (state_nx != S_RING) && (Minute == 8'h59);
  assign chime_lo  = chime_ok && lo_sec;
  assign chime_hi  = chime_ok && (Second == 8'h59);
  // Even ring seconds sound, odd ones are silent: 1 s on / 1 s off.
  assign ring_tone = (state == S_RING) && !ring_cnt[0] && hi_tone;

  always_ff @(posedge CLK or negedge nCR) begin
    if (!nCR) begin
      state    <= S_IDLE;
      sec_q    <= '0;
      min_q    <= '0;
      snooze_q <= 1'b0;
      stop_q   <= 1'b0;
      ring_cnt <= '0;
      min_cnt  <= '0;
      snz_cnt  <= '0;
      ALARM    <= 1'b0;
      Chiming  <= 1'b0;
      Ringing  <= 1'b0;
    end else begin
      state    <= state_nx;
      sec_q    <= Second;
      min_q    <= Minute;
      snooze_q <= Snooze;
      stop_q   <= Stop;

      if (ring_clr)
        ring_cnt <= '0;
      else if (ring_inc && (ring_cnt != 8'hFF))
        ring_cnt <= ring_cnt + 8'd1;

      if (min_clr)
        min_cnt <= '0;
      else if (min_inc)
        min_cnt <= min_cnt + 6'd1;

      if (snz_clr)
        snz_cnt <= '0;
      else if (snz_inc)
        snz_cnt <= snz_cnt + SNZ_W'(1);

      ALARM   <= ring_tone | (chime_lo & lo_tone) | (chime_hi & hi_tone);
      Chiming <= chime_lo | chime_hi;
      Ringing <= (state_nx == S_RING);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chime_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chime_alarm_ctrl
//  Purpose  : Self-checking bench for chime_alarm_ctrl: hourly pips from a
//             vector table, plus directed ring / snooze / stop / reset runs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_chime_alarm_ctrl;

  localparam int T_SIL = 0;
  localparam int T_LO  = 1;
  localparam int T_HI  = 2;

  logic       CLK = 1'b0;
  logic       nCR = 1'b0;
  logic [7:0] Hour = 8'h00, Minute = 8'h00, Second = 8'h00;
  logic       AlarmEn = 1'b0;
  logic [7:0] AlarmHour = 8'h00, AlarmMinute = 8'h00;
  logic       Snooze = 1'b0, Stop = 1'b0;
  logic       ALARM, Chiming, Ringing;

  int n_checks = 0;
  int n_pass   = 0;

  chime_alarm_ctrl dut (
    .CLK(CLK), .nCR(nCR), .Hour(Hour), .Minute(Minute), .Second(Second),
    .AlarmEn(AlarmEn), .AlarmHour(AlarmHour), .AlarmMinute(AlarmMinute),
    .Snooze(Snooze), .Stop(Stop), .ALARM(ALARM), .Chiming(Chiming),
    .Ringing(Ringing)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] h, m, s;
    int         tone;
    logic       chm;
    logic       rng;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drive a new time at the falling edge and let it propagate.
  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    @(negedge CLK);
    Hour = h; Minute = m; Second = s;
    repeat (3) @(posedge CLK);
  endtask

  // Classify ALARM over 8 falling-edge samples: silent, 500 Hz or 1 kHz.
  task automatic measure(output int cls);
    int ones, trans;
    logic prev;
    ones = 0; trans = 0; prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (ALARM) ones++;
      if (i > 0 && ALARM != prev) trans++;
      prev = ALARM;
    end
    if (ones == 0) cls = T_SIL;
    else if (trans >= 6) cls = T_HI;
    else if (trans >= 2 && trans <= 4 && ones >= 3 && ones <= 5) cls = T_LO;
    else cls = 3;
  endtask

  task automatic press(input logic snz, input logic stp);
    @(negedge CLK);
    Snooze = snz; Stop = stp;
    repeat (2) @(negedge CLK);
    Snooze = 1'b0; Stop = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int cls;
    string nm;

    for (int i = 0; i < 13; i++) begin
      vecs[i].h    = 8'h12;
      vecs[i].m    = 8'h59;
      vecs[i].s    = bcd(49 + i);
      vecs[i].tone = T_SIL;
      vecs[i].chm  = 1'b0;
      vecs[i].rng  = 1'b0;
    end
    vecs[2].tone = T_LO;  vecs[2].chm = 1'b1;   // s51
    vecs[4].tone = T_LO;  vecs[4].chm = 1'b1;   // s53
    vecs[6].tone = T_LO;  vecs[6].chm = 1'b1;   // s55
    vecs[8].tone = T_LO;  vecs[8].chm = 1'b1;   // s57
    vecs[10].tone = T_HI; vecs[10].chm = 1'b1;  // s59
    vecs[11].h = 8'h13; vecs[11].m = 8'h00; vecs[11].s = 8'h00;
    vecs[12].h = 8'h13; vecs[12].m = 8'h00; vecs[12].s = 8'h01;

    // ---- reset state ----
    repeat (3) @(posedge CLK);
    #1;
    check("reset_alarm", ALARM, 0);
    check("reset_chiming", Chiming, 0);
    check("reset_ringing", Ringing, 0);
    @(negedge CLK);
    nCR = 1'b1;

    // ---- hourly chime, alarm disabled ----
    for (int i = 0; i < 13; i++) begin
      set_time(vecs[i].h, vecs[i].m, vecs[i].s);
      measure(cls);
      $sformat(nm, "chime_tone[%0d]", i);
      check(nm, cls, vecs[i].tone);
      $sformat(nm, "chime_flag[%0d]", i);
      check(nm, Chiming, vecs[i].chm);
      $sformat(nm, "chime_ring[%0d]", i);
      check(nm, Ringing, vecs[i].rng);
    end

    // ---- alarm 07:30, full ring duration ----
    AlarmHour = 8'h07; AlarmMinute = 8'h30; AlarmEn = 1'b1;
    set_time(8'h07, 8'h29, 8'h59);
    check("pre_ring", Ringing, 0);
    @(negedge CLK);
    Second = 8'h00; Minute = 8'h30; Hour = 8'h07;
    @(posedge CLK); #1;
    check("ring_latency", Ringing, 1);
    measure(cls);
    check("ring_tone_s00", cls, T_HI);
    set_time(8'h07, 8'h30, 8'h01);
    measure(cls);
    check("ring_tone_s01", cls, T_SIL);
    for (int s = 2; s <= 59; s++) set_time(8'h07, 8'h30, bcd(s));
    check("ring_at_s59", Ringing, 1);
    set_time(8'h07, 8'h31, 8'h00);
    check("ring_timeout", Ringing, 0);
    measure(cls);
    check("ring_timeout_tone", cls, T_SIL);

    // ---- snooze three times, fourth ignored ----
    set_time(8'h07, 8'h29, 8'h59);
    set_time(8'h07, 8'h30, 8'h00);
    check("ring2_start", Ringing, 1);
    for (int n = 0; n < 3; n++) begin
      press(1'b1, 1'b0);
      $sformat(nm, "snooze%0d_quiet", n);
      check(nm, Ringing, 0);
      measure(cls);
      $sformat(nm, "snooze%0d_tone", n);
      check(nm, cls, T_SIL);
      for (int m = 1; m <= 4; m++) set_time(8'h07, bcd(30 + 5 * n + m), 8'h00);
      $sformat(nm, "snooze%0d_4min", n);
      check(nm, Ringing, 0);
      set_time(8'h07, bcd(35 + 5 * n), 8'h00);
      $sformat(nm, "snooze%0d_resume", n);
      check(nm, Ringing, 1);
    end
    press(1'b1, 1'b0);
    check("snooze4_ignored", Ringing, 1);
    measure(cls);
    check("snooze4_tone", cls, T_HI);
    press(1'b0, 1'b1);
    check("stop_ring", Ringing, 0);

    // ---- Stop and Snooze together ----
    AlarmHour = 8'h08; AlarmMinute = 8'h00;
    set_time(8'h07, 8'h59, 8'h59);
    set_time(8'h08, 8'h00, 8'h00);
    check("ring3_start", Ringing, 1);
    press(1'b1, 1'b1);
    check("both_keys_idle", Ringing, 0);
    for (int m = 1; m <= 6; m++) begin
      set_time(8'h08, bcd(m), 8'h00);
      if (m >= 5) begin
        $sformat(nm, "no_snooze_m%0d", m);
        check(nm, Ringing, 0);
      end
    end

    // ---- RING suppresses the chime ----
    AlarmHour = 8'h14; AlarmMinute = 8'h59;
    set_time(8'h14, 8'h58, 8'h59);
    set_time(8'h14, 8'h59, 8'h00);
    check("ring4_start", Ringing, 1);
    for (int s = 1; s <= 59; s++) begin
      set_time(8'h14, 8'h59, bcd(s));
      if (s >= 51) begin
        measure(cls);
        $sformat(nm, "nochime_tone_s%0d", s);
        check(nm, cls, (s % 2 == 0) ? T_HI : T_SIL);
        $sformat(nm, "nochime_flag_s%0d", s);
        check(nm, Chiming, 0);
      end
    end
    set_time(8'h15, 8'h00, 8'h00);
    check("ring4_end", Ringing, 0);

    // ---- AlarmEn dropped during RING ----
    AlarmHour = 8'h10; AlarmMinute = 8'h00;
    set_time(8'h09, 8'h59, 8'h58);
    set_time(8'h10, 8'h00, 8'h00);
    check("ring5_start", Ringing, 1);
    @(negedge CLK);
    AlarmEn = 1'b0;
    @(posedge CLK); #1;
    check("en_off_idle", Ringing, 0);
    @(negedge CLK);
    AlarmEn = 1'b1;
    repeat (3) @(posedge CLK); #1;
    check("en_on_no_retrigger", Ringing, 0);

    // ---- asynchronous reset mid-RING ----
    AlarmHour = 8'h11; AlarmMinute = 8'h00;
    set_time(8'h10, 8'h59, 8'h58);
    set_time(8'h11, 8'h00, 8'h00);
    check("ring6_start", Ringing, 1);
    @(posedge CLK); #2;
    nCR = 1'b0;
    #1;
    check("rst_alarm", ALARM, 0);
    check("rst_ringing", Ringing, 0);
    check("rst_chiming", Chiming, 0);
    @(negedge CLK);
    nCR = 1'b1;
    repeat (3) @(posedge CLK); #1;
    check("rst_release_idle", Ringing, 0);
    measure(cls);
    check("rst_release_tone", cls, T_SIL);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
